// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the Favor instruction sequencer: state encoding and
// default geometry of the fetch path.
package cpu_pkg;

    typedef enum logic [2:0] {
        SEQ_ISSUE   = 3'd0,
        SEQ_WAIT    = 3'd1,
        SEQ_DECODE  = 3'd2,
        SEQ_EXECUTE = 3'd3,
        SEQ_HALT    = 3'd4
    } seq_state_e;

    localparam int          DEF_INSN_BYTES = 4;
    localparam int          DEF_MEM_LAT    = 1;
    localparam logic [63:0] DEF_RESET_PC   = 64'd0;
    // Alignment shift k for the default instruction size.
    localparam int          ALIGN_SHIFT    = $clog2(DEF_INSN_BYTES);

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: issues BRAM reads, hands instructions to the decoder,
// waits for execute and owns the architectural PC (redirect, halt, resume).
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W       = 64,
    parameter int              ADDR_W     = 14,
    parameter int              INSN_W     = 32,
    parameter int              INSN_BYTES = DEF_INSN_BYTES,
    parameter int              MEM_LAT    = DEF_MEM_LAT,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [INSN_W-1:0] i_mem_data,
    output logic [INSN_W-1:0] o_insn,
    output logic              o_insn_valid,
    input  logic              i_insn_ready,
    input  logic              i_exec_done,
    input  logic              i_halt,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_pc,
    input  logic              i_resume,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_halted
);

    localparam int              K          = $clog2(INSN_BYTES);
    localparam int              LAT_W      = $clog2(MEM_LAT) + 1;
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(MEM_LAT - 1);
    localparam logic [PC_W-1:0] ONE_PC     = PC_W'(1);
    localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSN_BYTES);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~((ONE_PC << K) - ONE_PC);

    seq_state_e        state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_next_d;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              mem_rd_q;
    logic [INSN_W-1:0] insn_q;
    logic              insn_valid_q;
    logic              halted_q;

    // Next PC on leaving EXECUTE: aligned branch target or sequential step.
    always_comb begin
        if (i_redirect) begin
            pc_next_d = i_redirect_pc & ALIGN_MASK;
        end else begin
            pc_next_d = pc_q + PC_INC;
        end
    end

    // Sequencer FSM with registered outputs. Out of reset ISSUE spends one
    // cycle with the strobe low so the first pulse follows reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= SEQ_ISSUE;
            pc_q         <= RESET_PC;
            lat_cnt_q    <= '0;
            mem_rd_q     <= 1'b0;
            insn_q       <= '0;
            insn_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                SEQ_ISSUE: begin
                    if (mem_rd_q) begin
                        mem_rd_q  <= 1'b0;
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= SEQ_WAIT;
                    end else begin
                        mem_rd_q  <= 1'b1;
                    end
                end
                SEQ_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        insn_q       <= i_mem_data;
                        insn_valid_q <= 1'b1;
                        state_q      <= SEQ_DECODE;
                    end else begin
                        lat_cnt_q    <= lat_cnt_q - LAT_W'(1);
                    end
                end
                SEQ_DECODE: begin
                    if (i_insn_ready) begin
                        insn_valid_q <= 1'b0;
                        state_q      <= SEQ_EXECUTE;
                    end else begin
                        insn_valid_q <= 1'b1;
                    end
                end
                SEQ_EXECUTE: begin
                    if (i_exec_done) begin
                        pc_q <= pc_next_d;
                        if (i_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= SEQ_HALT;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= SEQ_ISSUE;
                        end
                    end else begin
                        state_q <= SEQ_EXECUTE;
                    end
                end
                SEQ_HALT: begin
                    if (i_resume) begin
                        halted_q <= 1'b0;
                        mem_rd_q <= 1'b1;
                        state_q  <= SEQ_ISSUE;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= SEQ_ISSUE;
                    mem_rd_q     <= 1'b0;
                    insn_valid_q <= 1'b0;
                    halted_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rd     = mem_rd_q;
    assign o_mem_addr   = pc_q[ADDR_W-1:0];
    assign o_insn       = insn_q;
    assign o_insn_valid = insn_valid_q;
    assign o_pc         = pc_q;
    assign o_halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a default instance (MEM_LAT=1, PC_W=64) and a
// narrow slow instance (MEM_LAT=3, PC_W=16), each fed by a pipelined BRAM model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        case (a)
            14'h0000: return 32'h0000_0011;
            14'h0004: return 32'h0000_0022;
            14'h0008: return 32'h0000_0033;
            default:  return 32'h1000_0000 | {18'h0, a};
        endcase
    endfunction

    // Instance A: defaults
    logic        a_rst_n = 1'b0;
    logic        a_rd, a_valid, a_halted;
    logic [13:0] a_addr;
    logic [31:0] a_mem_data, a_insn;
    logic        a_ready = 1'b0, a_done = 1'b0, a_halt = 1'b0, a_redir = 1'b0, a_resume = 1'b0;
    logic [63:0] a_redir_pc = 64'd0;
    logic [63:0] a_pc;

    fetch_sequencer u_dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .o_mem_rd(a_rd), .o_mem_addr(a_addr),
        .i_mem_data(a_mem_data), .o_insn(a_insn), .o_insn_valid(a_valid),
        .i_insn_ready(a_ready), .i_exec_done(a_done), .i_halt(a_halt),
        .i_redirect(a_redir), .i_redirect_pc(a_redir_pc), .i_resume(a_resume),
        .o_pc(a_pc), .o_halted(a_halted)
    );

    // Instance B: 16-bit PC, three-cycle memory, non-zero reset PC
    logic        b_rst_n = 1'b0;
    logic        b_rd, b_valid, b_halted;
    logic [13:0] b_addr;
    logic [31:0] b_mem_data, b_insn;
    logic        b_ready = 1'b0, b_done = 1'b0, b_halt = 1'b0, b_redir = 1'b0, b_resume = 1'b0;
    logic [15:0] b_redir_pc = 16'd0;
    logic [15:0] b_pc;

    fetch_sequencer #(.PC_W(16), .ADDR_W(14), .INSN_W(32), .INSN_BYTES(4),
                      .MEM_LAT(3), .RESET_PC(16'h0200)) u_dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .o_mem_rd(b_rd), .o_mem_addr(b_addr),
        .i_mem_data(b_mem_data), .o_insn(b_insn), .o_insn_valid(b_valid),
        .i_insn_ready(b_ready), .i_exec_done(b_done), .i_halt(b_halt),
        .i_redirect(b_redir), .i_redirect_pc(b_redir_pc), .i_resume(b_resume),
        .o_pc(b_pc), .o_halted(b_halted)
    );

    // BRAM models: data is meaningful only MEM_LAT cycles after a strobe, noise otherwise
    logic        a_pv = 1'b0;
    logic [13:0] a_pa = 14'd0;
    logic [31:0] a_noise = 32'd0;
    logic [2:0]  b_pv = 3'd0;
    logic [13:0] b_pa0 = 14'd0, b_pa1 = 14'd0, b_pa2 = 14'd0;
    logic [31:0] b_noise = 32'd0;

    always @(posedge clk) begin
        a_pv    <= a_rd;
        a_pa    <= a_addr;
        a_noise <= $urandom;
        b_pv    <= {b_pv[1:0], b_rd};
        b_pa0   <= b_addr;
        b_pa1   <= b_pa0;
        b_pa2   <= b_pa1;
        b_noise <= $urandom;
    end

    assign a_mem_data = a_pv    ? mem_word(a_pa)  : a_noise;
    assign b_mem_data = b_pv[2] ? mem_word(b_pa2) : b_noise;

    // Scoreboards: tests push expected strobe addresses; each strobe pushes the
    // instruction the decoder must later see.
    logic [13:0] a_exp_addr[$], b_exp_addr[$];
    logic [31:0] a_exp_insn[$], b_exp_insn[$];

    initial begin
        logic        a_vp, b_vp;
        logic [13:0] ea;
        logic [31:0] ei;
        a_vp = 1'b0;
        b_vp = 1'b0;
        forever begin
            @(negedge clk);
            if (a_rd) begin
                checks++;
                if (a_exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL a_strobe_unexpected: addr=%h", a_addr);
                end else begin
                    ea = a_exp_addr.pop_front();
                    if (a_addr !== ea) begin
                        errors++;
                        $display("FAIL a_strobe_addr: got %h expected %h", a_addr, ea);
                    end
                end
                a_exp_insn.push_back(mem_word(a_addr));
            end
            if (a_valid && !a_vp) begin
                checks++;
                if (a_exp_insn.size() == 0) begin
                    errors++;
                    $display("FAIL a_insn_unexpected: insn=%h", a_insn);
                end else begin
                    ei = a_exp_insn.pop_front();
                    if (a_insn !== ei) begin
                        errors++;
                        $display("FAIL a_insn: got %h expected %h", a_insn, ei);
                    end
                end
            end
            a_vp = a_valid;
            if (b_rd) begin
                checks++;
                if (b_exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL b_strobe_unexpected: addr=%h", b_addr);
                end else begin
                    ea = b_exp_addr.pop_front();
                    if (b_addr !== ea) begin
                        errors++;
                        $display("FAIL b_strobe_addr: got %h expected %h", b_addr, ea);
                    end
                end
                b_exp_insn.push_back(mem_word(b_addr));
            end
            if (b_valid && !b_vp) begin
                checks++;
                if (b_exp_insn.size() == 0) begin
                    errors++;
                    $display("FAIL b_insn_unexpected: insn=%h", b_insn);
                end else begin
                    ei = b_exp_insn.pop_front();
                    if (b_insn !== ei) begin
                        errors++;
                        $display("FAIL b_insn: got %h expected %h", b_insn, ei);
                    end
                end
            end
            b_vp = b_valid;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        wait_cycles(2);
        checks++;
        if ({a_rd, a_valid, a_halted} !== 3'b000 || a_addr !== 14'h0 || a_insn !== 32'h0 || a_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_a: rd=%b valid=%b halted=%b addr=%h insn=%h pc=%h expected all zero",
                     a_rd, a_valid, a_halted, a_addr, a_insn, a_pc);
        end
        checks++;
        if ({b_rd, b_valid, b_halted} !== 3'b000 || b_addr !== 14'h0200 || b_insn !== 32'h0 || b_pc !== 16'h0200) begin
            errors++;
            $display("FAIL reset_b: rd=%b valid=%b halted=%b addr=%h insn=%h pc=%h expected 0/0/0/0200/0/0200",
                     b_rd, b_valid, b_halted, b_addr, b_insn, b_pc);
        end
    endtask

    task automatic test_straight_line;
        int s[3];
        int n;
        n = 0;
        a_exp_addr.push_back(14'h0);
        a_exp_addr.push_back(14'h4);
        a_exp_addr.push_back(14'h8);
        a_ready = 1'b1;
        a_done  = 1'b1;
        a_rst_n = 1'b1;
        for (int i = 1; i <= 20 && n < 3; i++) begin
            @(negedge clk);
            if (a_rd) begin
                s[n] = i;
                n++;
                if (n == 3) a_done = 1'b0;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL straight_timeout: strobes seen %0d expected 3", n);
        end else begin
            checks++;
            if (s[0] != 1) begin
                errors++;
                $display("FAIL first_strobe: cycle %0d expected 1", s[0]);
            end
            checks++;
            if (s[1] - s[0] != 4 || s[2] - s[1] != 4) begin
                errors++;
                $display("FAIL straight_period: gaps %0d %0d expected 4 4", s[1] - s[0], s[2] - s[1]);
            end
        end
        wait_cycles(6);
        checks++;
        if (a_pc !== 64'h8 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL straight_park: pc=%h valid=%b expected 8 0", a_pc, a_valid);
        end
    endtask

    task automatic test_redirect;
        a_exp_addr.push_back(14'h100);
        a_done = 1'b1; a_redir = 1'b1; a_redir_pc = 64'h103;
        @(negedge clk);
        a_done = 1'b0; a_redir = 1'b0;
        checks++;
        if (a_pc !== 64'h100 || a_rd !== 1'b1) begin
            errors++;
            $display("FAIL redirect: pc=%h rd=%b expected 100 1", a_pc, a_rd);
        end
        wait_cycles(6);
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        bit seen;
        seen = 1'b0;
        a_ready = 1'b0;
        a_exp_addr.push_back(14'h104);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (a_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL backpressure_timeout: valid=%b expected 1", a_valid);
        end
        held = a_insn;
        for (int k = 0; k < 5; k++) begin
            a_done = (k == 1);
            a_halt = (k == 1);
            @(negedge clk);
            checks++;
            if (a_valid !== 1'b1 || a_insn !== held || a_rd !== 1'b0 || a_pc !== 64'h104 || a_halted !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: k=%0d valid=%b insn=%h rd=%b pc=%h halted=%b expected 1 %h 0 104 0",
                         k, a_valid, a_insn, a_rd, a_pc, a_halted, held);
            end
        end
        a_done = 1'b0; a_halt = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b expected 0", a_valid);
        end
        wait_cycles(3);
    endtask

    task automatic test_halt_resume;
        a_exp_addr.push_back(14'h10);
        a_done = 1'b1; a_redir = 1'b1; a_redir_pc = 64'h10;
        @(negedge clk);
        a_done = 1'b0; a_redir = 1'b0;
        wait_cycles(6);
        checks++;
        if (a_pc !== 64'h10) begin
            errors++;
            $display("FAIL halt_setup_pc: got %h expected 10", a_pc);
        end
        a_done = 1'b1; a_halt = 1'b1; a_redir = 1'b1; a_redir_pc = 64'h40;
        @(negedge clk);
        a_done = 1'b0; a_halt = 1'b0; a_redir = 1'b0;
        checks++;
        if (a_halted !== 1'b1 || a_pc !== 64'h40) begin
            errors++;
            $display("FAIL halt_enter: halted=%b pc=%h expected 1 40", a_halted, a_pc);
        end
        for (int k = 0; k < 10; k++) begin
            a_done  = (k == 3);
            a_redir = (k == 3);
            a_redir_pc = 64'h200;
            @(negedge clk);
            checks++;
            if (a_halted !== 1'b1 || a_rd !== 1'b0 || a_pc !== 64'h40) begin
                errors++;
                $display("FAIL halt_hold: k=%0d halted=%b rd=%b pc=%h expected 1 0 40", k, a_halted, a_rd, a_pc);
            end
        end
        a_done = 1'b0; a_redir = 1'b0;
        a_exp_addr.push_back(14'h40);
        a_resume = 1'b1;
        @(negedge clk);
        a_resume = 1'b0;
        checks++;
        if (a_rd !== 1'b1 || a_halted !== 1'b0 || a_pc !== 64'h40) begin
            errors++;
            $display("FAIL resume: rd=%b halted=%b pc=%h expected 1 0 40", a_rd, a_halted, a_pc);
        end
        wait_cycles(6);
    endtask

    task automatic test_latency;
        int s[2];
        int n, v;
        logic vp;
        n = 0; v = -1; vp = 1'b0;
        b_exp_addr.push_back(14'h0200);
        b_exp_addr.push_back(14'h0204);
        b_ready = 1'b1;
        b_done  = 1'b1;
        b_rst_n = 1'b1;
        for (int i = 1; i <= 30 && n < 2; i++) begin
            @(negedge clk);
            if (b_valid && !vp && v < 0) v = i;
            vp = b_valid;
            if (b_rd) begin
                s[n] = i;
                n++;
                if (n == 2) b_done = 1'b0;
            end
        end
        checks++;
        if (n != 2 || v < 0) begin
            errors++;
            $display("FAIL latency_timeout: strobes %0d valid_seen=%0d expected 2 strobes and a valid", n, v);
        end else begin
            checks++;
            if (v - s[0] != 4) begin
                errors++;
                $display("FAIL latency_valid: strobe-to-valid %0d expected 4", v - s[0]);
            end
            checks++;
            if (s[1] - s[0] != 6) begin
                errors++;
                $display("FAIL latency_period: %0d expected 6", s[1] - s[0]);
            end
        end
        wait_cycles(8);
    endtask

    task automatic test_wrap_and_reset;
        b_exp_addr.push_back(14'h3FFC);
        b_done = 1'b1; b_redir = 1'b1; b_redir_pc = 16'hFFFC;
        @(negedge clk);
        b_done = 1'b0; b_redir = 1'b0;
        checks++;
        if (b_pc !== 16'hFFFC) begin
            errors++;
            $display("FAIL wrap_setup_pc: got %h expected fffc", b_pc);
        end
        wait_cycles(8);
        b_exp_addr.push_back(14'h0000);
        b_done = 1'b1;
        @(negedge clk);
        b_done = 1'b0;
        checks++;
        if (b_pc !== 16'h0000 || b_rd !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc=%h rd=%b expected 0000 1", b_pc, b_rd);
        end
        @(negedge clk);
        b_rst_n = 1'b0;
        #1;
        b_exp_insn.delete();
        checks++;
        if ({b_rd, b_valid, b_halted} !== 3'b000 || b_addr !== 14'h0200 || b_insn !== 32'h0 || b_pc !== 16'h0200) begin
            errors++;
            $display("FAIL async_reset: rd=%b valid=%b halted=%b addr=%h insn=%h pc=%h expected 0/0/0/0200/0/0200",
                     b_rd, b_valid, b_halted, b_addr, b_insn, b_pc);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (b_valid !== 1'b0 || b_insn !== 32'h0) begin
                errors++;
                $display("FAIL reset_no_capture: k=%0d valid=%b insn=%h expected 0 0", k, b_valid, b_insn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_redirect();
        test_backpressure();
        test_halt_resume();
        test_latency();
        test_wrap_and_reset();
        checks++;
        if (a_exp_addr.size() != 0 || b_exp_addr.size() != 0 || a_exp_insn.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending a_addr=%0d b_addr=%0d a_insn=%0d expected 0 0 0",
                     a_exp_addr.size(), b_exp_addr.size(), a_exp_insn.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction-sequencing unit for the Favor core. It replaces the fixed four-state fetch/decode/execute loop with a generalised sequencer that supports configurable PC width, memory address width and memory read latency. It also adds a decoder valid/ready handshake, a variable-length execute stage, branch redirects and a resumable halt. It sits between the instruction BRAM and the decoder/execute logic, and owns the architectural PC.

## Interface

- `PC_W`, default 64: width of the program counter.
- `ADDR_W`, default 14: width of the memory byte address (low bits of the PC).
- `INSN_W`, default 32: instruction width.
- `INSN_BYTES`, default 4: PC increment per instruction; must be a power of two.
- `MEM_LAT`, default 1: memory read latency in cycles; must be at least 1.
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:

- `i_clk` in 1: clock. One clock; reset is asynchronous and active-low.
- `i_rst_n` in 1: asynchronous active-low reset.
- `o_mem_rd` out 1: read strobe, high for exactly one cycle per fetch.
- `o_mem_addr` out ADDR_W: read address, equal to `pc[ADDR_W-1:0]`.
- `i_mem_data` in INSN_W: read data, valid MEM_LAT cycles after the strobe cycle.
- `o_insn` out INSN_W: captured instruction.
- `o_insn_valid` out 1: instruction offered to the decoder.
- `i_insn_ready` in 1: decoder accepts `o_insn`.
- `i_exec_done` in 1: execute stage complete.
- `i_halt` in 1: the executing instruction is a halt. Sampled only with `i_exec_done`.
- `i_redirect` in 1: take a branch. Sampled only with `i_exec_done`.
- `i_redirect_pc` in PC_W: branch target.
- `i_resume` in 1: leave HALT.
- `o_pc` out PC_W: address of the instruction currently in flight.
- `o_halted` out 1: state is HALT.

## Operation

States: ISSUE, WAIT, DECODE, EXECUTE, HALT. The encoding is shared via the package.

- **ISSUE:** `o_mem_rd=1` and `o_mem_addr=pc[ADDR_W-1:0]`. Load `lat_cnt=MEM_LAT-1`, then go to WAIT.
- **WAIT:** `o_mem_rd=0`.
  - If `lat_cnt==0`: capture `i_mem_data` into `o_insn`, set `o_insn_valid=1`, go to DECODE.
  - Otherwise decrement `lat_cnt`.
- **DECODE:** hold `o_insn` and `o_insn_valid` stable until `i_insn_ready`. On handshake, clear `o_insn_valid` and go to EXECUTE.
- **EXECUTE:** wait for `i_exec_done`, then compute the next PC and state:
  - Next PC is `{i_redirect_pc[PC_W-1:k], k'b0}` if `i_redirect`, else `pc+INSN_BYTES` modulo 2^PC_W, where k = log2(INSN_BYTES). Misaligned targets are silently aligned down.
  - Next state is HALT if `i_halt`, else ISSUE.
  - Halt and redirect asserted together: halt wins the state, and the redirect target is still loaded into the PC.
- **HALT:** `o_halted=1`. On `i_resume`, go to ISSUE with the PC unchanged (fetch resumes after the halt instruction).
- **Ignored inputs:** `i_exec_done`, `i_halt` and `i_redirect` are ignored outside EXECUTE. `i_resume` is ignored outside HALT. `i_insn_ready` is ignored when `o_insn_valid=0`.
- **PC wrap:** the PC wraps from `2^PC_W - INSN_BYTES` to 0. `o_mem_addr` wraps naturally by truncation.

## Timing

- **Reset values:**
  - state ISSUE, `pc=RESET_PC`, `lat_cnt=0`;
  - `o_mem_rd=0`, `o_mem_addr=RESET_PC[ADDR_W-1:0]`;
  - `o_insn=0`, `o_insn_valid=0`, `o_halted=0`, `o_pc=RESET_PC`.
- **First strobe:** the first `o_mem_rd` pulse occurs in the first cycle after `i_rst_n` deasserts.
- **Reset mid-operation:** asserting reset in any state immediately aborts the fetch in flight and clears `o_insn_valid`; no outstanding memory data is captured.
- **Fetch latency:** strobe to `o_insn_valid` is MEM_LAT+1 cycles; `o_insn_valid` rises on the edge ending the last WAIT cycle.
- **Throughput:** minimum of MEM_LAT+3 cycles per instruction, reached when `i_insn_ready` and `i_exec_done` are held high.
- **Register updates:** `o_pc` and `pc` update only on the edge leaving EXECUTE. `o_halted` rises on that same edge when halting.
- **Outputs:** all outputs are registered or decoded from registered state only; there is no input-to-output combinational path.

## Structure

- **Shared package `cpu_pkg`:**
  - the state enum (`SEQ_ISSUE`, `SEQ_WAIT`, `SEQ_DECODE`, `SEQ_EXECUTE`, `SEQ_HALT`);
  - the default `INSN_BYTES`, `RESET_PC` and `MEM_LAT`;
  - the localparam for the alignment shift k.
- **Sub-modules:** none. The latency counter (`$clog2(MEM_LAT)+1` bits) and the PC-next mux stay inline. The BRAM and the decoder remain external.

## Test plan

- **Reset and straight-line fetch:** reset with RESET_PC=0 and MEM_LAT=1, memory holding 0x11,0x22,0x33 at 0,4,8; ready and done held high.
  - Expect strobes at addresses 0,4,8, one every 4 cycles.
  - Expect `o_insn` = 0x11, 0x22, 0x33 in order.
- **Latency sweep:** MEM_LAT=3. Expect valid 4 cycles after the strobe and a 6-cycle instruction period; `i_mem_data` changed before the capture cycle must not be captured.
- **Backpressure:** hold `i_insn_ready=0` for 5 cycles in DECODE.
  - Expect `o_insn_valid` and `o_insn` stable throughout.
  - Expect no new strobe and `o_pc` unchanged.
- **Redirect:** done with redirect to 0x103 while pc=0x8. Expect the next strobe at 0x100 and `o_pc=0x100`.
- **Halt and resume:** done with halt and redirect to 0x40 together at pc=0x10.
  - Expect `o_halted=1` and `pc=0x40`, with no strobes for 10 cycles.
  - On `i_resume`, expect a strobe at 0x40.
- **Wrap and async reset:** with PC_W=16, pc=0xFFFC and done, expect the next fetch at 0x0000. Assert `i_rst_n=0` mid-WAIT: outputs reach their reset values before the next edge, and there is no capture.
